onchip_ram_arbiter: RTL and testbench
=====================================

Name: onchip_ram_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the 42500 x 32 single-port on-chip RAM.
- Shares the RAM between the mSGDMA master (m0, high priority) and the HPS lightweight bridge (m1, low priority).
- Starvation counter guarantees m1 service under sustained m0 load.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken and returns readdata with a fixed 1-cycle read latency.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 32, data width; byteenable width = DATA_W/8.
- DEPTH, 42500, number of valid RAM words.
- MAX_WAIT, 8, consecutive cycles m1 may be refused while requesting before it is forced to win.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  DMA word address
- m0_byteenable  in  4  DMA byte enables
- m0_read  in  1  DMA read request
- m0_write  in  1  DMA write request
- m0_writedata  in  DATA_W  DMA write data
- m0_waitrequest  out  1  DMA stall
- m0_readdata  out  DATA_W  DMA read data
- m0_readdatavalid  out  1  DMA read data valid
- m1_*  same set as m0_*  HPS requester
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  4  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  to RAM clock enable
- ram_readdata  in  DATA_W  RAM q (valid 1 cycle after address)
- starve_events  out  16  saturating count of forced m1 grants

Behaviour:
- Request: req_x = mx_read | mx_write. If both are asserted, the write wins and the read is ignored.
- Grant (combinational):
  - m1 wins if starve_cnt == MAX_WAIT and req_1.
  - Otherwise m0 wins if req_0.
  - Otherwise m1 wins if req_1.
  - Otherwise no grant.
- Waitrequest: mx_waitrequest = req_x & ~grant_x. A granted access is accepted in that same cycle.
- RAM outputs:
  - ram_chipselect = any grant.
  - ram_write = granted master's write.
  - ram_address, ram_byteenable and ram_writedata are muxed from the winner; they are 0 when there is no grant.
  - ram_clken = reset_n synchronised through 2 flops, so it is low during and for 2 cycles after reset.
- starve_cnt (width clog2(MAX_WAIT+1)):
  - Increments when req_1 & ~grant_1.
  - Clears when grant_1 or ~req_1.
  - Never exceeds MAX_WAIT.
- starve_events: increments by 1, saturating at 0xFFFF, on every cycle where grant_1 is caused by starve_cnt == MAX_WAIT with req_0 also high.
- Read return:
  - An accepted read sets rd_pend = 1 and rd_id = winner.
  - Next cycle: m{rd_id}_readdatavalid = 1, and readdata = ram_readdata (unregistered passthrough; both mx_readdata carry ram_readdata).
  - Back-to-back reads give one valid per cycle with no bubble.
- Writes: no response phase.
- Reset (async assert, sync release):
  - rd_pend, starve_cnt, starve_events, ram_clken sync flops → 0.
  - All readdatavalid → 0.
  - While reset_n is low, no grant is issued: waitrequest = req_x, ram_chipselect = 0.
  - A read accepted in the cycle reset asserts gets no readdatavalid.
- Boundary conditions:
  - Simultaneous m0 and m1 requests with starve_cnt < MAX_WAIT: m0 served, m1 stalls, counter +1.
  - MAX_WAIT = 0: m1 always wins ties (strict m1 priority).

Optional Feature:
- Macro: ONCHIP_ARB_BOUNDS_CHECK_EN.
- Defined:
  - An accepted access with address >= DEPTH does not reach the RAM (ram_chipselect = 0 that cycle).
  - Writes are dropped.
  - Reads still produce readdatavalid next cycle, with readdata = 32'hDEAD_BEEF for that requester only.
  - Sticky output oob_err (1 bit, reset 0) sets, and clears only on reset.
- Undefined: no address check, no oob_err port; the address passes straight through (RAM aliases).

Decomposition:
- Package onchip_arb_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - OOB_PATTERN = 32'hDEAD_BEEF.
  - Requester id typedef (ID_DMA = 0, ID_HPS = 1).
- One natural sub-module, onchip_arb_grant: priority and starvation logic (starve_cnt, grant vector, forced flag).
- Datapath mux and read-return pipeline stay in the top module.

Test Plan:
- Single m1 write addr 0x0010, data 0x12345678, be 4'hF, then read 0x0010 → waitrequest 0 both cycles; readdatavalid on m1 one cycle after the read with 0x12345678.
- m0 and m1 request continuously, MAX_WAIT = 8 → m0 granted 8 cycles, m1 granted on cycle 9; pattern repeats; starve_events increments each forced grant.
- Back-to-back m0 reads of 0,1,2,3 → readdatavalid high 4 consecutive cycles with the matching words; m1_readdatavalid stays 0.
- Byte-enable write be = 4'b0010, data 0xAABBCCDD over 0x00000000, then read → 0x0000CC00.
- reset_n dropped the cycle after a read is accepted → no readdatavalid; ram_clken low; after release, ram_clken rises on the 2nd clock and the first request is served normally.
- With ONCHIP_ARB_BOUNDS_CHECK_EN, m0 read addr 42500 → readdata 0xDEADBEEF, oob_err = 1, ram_chipselect 0 that cycle.

Source files
------------

// File: rtl/onchip_arb_pkg.sv
// Shared constants and types for the on-chip RAM arbiter (DMA + HPS requesters).
package onchip_arb_pkg;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 42500;
    localparam int MAX_WAIT_DEF = 8;

    localparam logic [31:0] OOB_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic {
        ID_DMA = 1'b0,
        ID_HPS = 1'b1
    } req_id_t;

    // Width of the starvation counter; a MAX_WAIT of 0 still needs one bit.
    function automatic int cnt_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/onchip_arb_grant.sv
// Fixed-priority grant (m0 over m1) with a starvation counter that forces
// an m1 grant after MAX_WAIT consecutive refused cycles.
module onchip_arb_grant
    import onchip_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    output logic grant_0,
    output logic grant_1,
    output logic forced
);

    localparam int CNT_W = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;

    always_comb begin
        forced  = req_1 && (starve_cnt == CNT_MAX);
        grant_1 = forced || (req_1 && !req_0);
        grant_0 = req_0 && !forced;

        starve_nxt = starve_cnt;
        if (!req_1 || grant_1) begin
            starve_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of a single-port on-chip RAM.
// Optional address bounds checking is enabled by ONCHIP_ARB_BOUNDS_CHECK_EN.
module onchip_ram_arbiter #(
    parameter int ADDR_W = onchip_arb_pkg::ADDR_W,
    parameter int DATA_W = onchip_arb_pkg::DATA_W,
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    parameter int DEPTH = onchip_arb_pkg::DEPTH,
`endif
    parameter int MAX_WAIT = onchip_arb_pkg::MAX_WAIT_DEF,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,

    output logic [15:0]       starve_events
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    ,
    output logic              oob_err
`endif
);

    import onchip_arb_pkg::*;

    // Handshake: a request (read or write) is accepted in any cycle where its
    // waitrequest is low; write wins over read when both are set; an accepted
    // read returns readdatavalid exactly one cycle later, one per cycle.
    logic req_0, req_1;
    logic req_0_g, req_1_g;
    logic grant_0, grant_1, forced;
    logic any_grant;
    req_id_t winner;

    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_write;
    logic              sel_read;
    logic              blocked;
    logic              rd_accept;

    logic    rd_pend;
    req_id_t rd_id;
    logic [1:0] clken_sync;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // No grant may be issued while reset is held low.
    assign req_0_g = req_0 & reset_n;
    assign req_1_g = req_1 & reset_n;

    onchip_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk     (clk),
        .rst_n   (reset_n),
        .req_0   (req_0_g),
        .req_1   (req_1_g),
        .grant_0 (grant_0),
        .grant_1 (grant_1),
        .forced  (forced)
    );

    assign any_grant      = grant_0 | grant_1;
    assign winner         = grant_1 ? ID_HPS : ID_DMA;
    assign m0_waitrequest = req_0 & ~grant_0;
    assign m1_waitrequest = req_1 & ~grant_1;

    always_comb begin
        sel_address    = '0;
        sel_byteenable = '0;
        sel_writedata  = '0;
        sel_write      = 1'b0;
        sel_read       = 1'b0;
        if (grant_0) begin
            sel_address    = m0_address;
            sel_byteenable = m0_byteenable;
            sel_writedata  = m0_writedata;
            sel_write      = m0_write;
            sel_read       = m0_read & ~m0_write;
        end else if (grant_1) begin
            sel_address    = m1_address;
            sel_byteenable = m1_byteenable;
            sel_writedata  = m1_writedata;
            sel_write      = m1_write;
            sel_read       = m1_read & ~m1_write;
        end
    end

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    assign blocked = any_grant && (32'(sel_address) >= DEPTH);
`else
    assign blocked = 1'b0;
`endif

    assign ram_address    = sel_address;
    assign ram_byteenable = sel_byteenable;
    assign ram_writedata  = sel_writedata;
    assign ram_chipselect = any_grant & ~blocked;
    assign ram_write      = sel_write & ~blocked;
    assign ram_clken      = clken_sync[1];

    // Out-of-range reads are still accepted and answered, just not from RAM.
    assign rd_accept = any_grant & sel_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend    <= 1'b0;
            rd_id      <= ID_DMA;
            clken_sync <= 2'b00;
        end else begin
            rd_pend    <= rd_accept;
            rd_id      <= winner;
            clken_sync <= {clken_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_events <= '0;
        end else if (forced && req_0_g && (starve_events != 16'hFFFF)) begin
            starve_events <= starve_events + 16'd1;
        end
    end

    assign m0_readdatavalid = rd_pend && (rd_id == ID_DMA);
    assign m1_readdatavalid = rd_pend && (rd_id == ID_HPS);

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    logic rd_oob;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_oob  <= 1'b0;
            oob_err <= 1'b0;
        end else begin
            rd_oob <= blocked;
            if (blocked) begin
                oob_err <= 1'b1;
            end
        end
    end

    // The poison pattern goes only to the requester that made the bad read.
    assign m0_readdata = (m0_readdatavalid && rd_oob) ? DATA_W'(OOB_PATTERN) : ram_readdata;
    assign m1_readdata = (m1_readdatavalid && rd_oob) ? DATA_W'(OOB_PATTERN) : ram_readdata;
`else
    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;
`endif

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_onchip_ram_arbiter;
  import onchip_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic [15:0] starve_events;
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
  logic        oob_err;
`endif

  onchip_ram_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .starve_events    (starve_events)
`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    ,
    .oob_err          (oob_err)
`endif
  );

  // ---------------- behavioural single-port RAM (1-cycle read) ----------------
  logic [31:0] mem [0:65535];
  logic [31:0] ram_q;
  assign ram_readdata = ram_q;

  initial begin
    ram_q = '0;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
  end

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end
      ram_q <= mem[ram_address];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (m0_readdatavalid) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m0_rdata unexpected valid actual=%h required=none", m0_readdata);
      end else begin
        e = exp_q0.pop_front();
        chk("m0_rdata", m0_readdata, e);
      end
    end
    if (m1_readdatavalid) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m1_rdata unexpected valid actual=%h required=none", m1_readdata);
      end else begin
        e = exp_q1.pop_front();
        chk("m1_rdata", m1_readdata, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_m(input int idx, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    if (idx == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clken_release();
    @(posedge clk);
    @(negedge clk);
    chk("clken_clk1", ram_clken, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("clken_clk2", ram_clken, 1'b1);
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle_all();
    m0_read = 1'b1;
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_cs", ram_chipselect, 1'b0);
    chk("rst_clken", ram_clken, 1'b0);
    chk("rst_starve", starve_events, 16'd0);
    chk("rst_m0_rdv", m0_readdatavalid, 1'b0);
    step();
    m0_read = 1'b0;
    reset_n = 1'b1;
    wait_clken_release();

    // single m1 write then read back
    set_m(1, 1'b0, 1'b1, 16'h0010, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("m1_wr_wait", m1_waitrequest, 1'b0);
    chk("m1_wr_cs", ram_chipselect, 1'b1);
    chk("m1_wr_we", ram_write, 1'b1);
    chk("m1_wr_addr", ram_address, 16'h0010);
    step();
    set_m(1, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
    exp_q1.push_back(32'h1234_5678);
    @(negedge clk);
    chk("m1_rd_wait", m1_waitrequest, 1'b0);
    chk("m1_rd_we", ram_write, 1'b0);
    step();
    idle_all();
    @(negedge clk);
    chk("m1_rdv_lat", m1_readdatavalid, 1'b1);
    step();

    // m0 writes 0..3, then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1'b0, 1'b1, 16'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1'b1, 1'b0, 16'(i), 32'h0, 4'hF);
      exp_q0.push_back(32'hC0DE_0000 + 32'(i));
      @(negedge clk);
      chk("b2b_wait", m0_waitrequest, 1'b0);
      if (i > 0) chk("b2b_rdv", m0_readdatavalid, 1'b1);
      step();
    end
    idle_all();
    @(negedge clk);
    chk("b2b_rdv_last", m0_readdatavalid, 1'b1);
    chk("b2b_m1_rdv", m1_readdatavalid, 1'b0);
    step();
    @(negedge clk);
    chk("b2b_rdv_end", m0_readdatavalid, 1'b0);
    step();

    // byte-enable write over zero
    set_m(0, 1'b0, 1'b1, 16'h0020, 32'h0, 4'hF);
    step();
    set_m(0, 1'b0, 1'b1, 16'h0020, 32'hAABB_CCDD, 4'b0010);
    step();
    set_m(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
    exp_q0.push_back(32'h0000_CC00);
    step();
    idle_all();
    step();

    // sustained contention: m1 forced through on every 9th cycle
    set_m(0, 1'b0, 1'b1, 16'h0100, 32'h1, 4'hF);
    set_m(1, 1'b0, 1'b1, 16'h0101, 32'h2, 4'hF);
    for (int c = 0; c < 18; c++) begin
      logic exp_g1;
      exp_g1 = ((c % 9) == 8);
      @(negedge clk);
      chk("arb_m1_wait", m1_waitrequest, !exp_g1);
      chk("arb_m0_wait", m0_waitrequest, exp_g1);
      if (c == 9) chk("arb_starve_1", starve_events, 16'd1);
      step();
    end
    idle_all();
    @(negedge clk);
    chk("arb_starve_2", starve_events, 16'd2);
    step();

    // reset asserted the cycle after a read is accepted
    set_m(0, 1'b1, 1'b0, 16'h0020, 32'h0, 4'hF);
    @(negedge clk);
    chk("rst_rd_wait", m0_waitrequest, 1'b0);
    step();
    reset_n = 1'b0;
    idle_all();
    @(negedge clk);
    chk("rst_rd_rdv", m0_readdatavalid, 1'b0);
    chk("rst_rd_clken", ram_clken, 1'b0);
    chk("rst_rd_starve", starve_events, 16'd0);
    step();
    reset_n = 1'b1;
    wait_clken_release();
    set_m(1, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF);
    exp_q1.push_back(32'h1234_5678);
    @(negedge clk);
    chk("post_rst_wait", m1_waitrequest, 1'b0);
    step();
    idle_all();
    @(negedge clk);
    chk("post_rst_rdv", m1_readdatavalid, 1'b1);
    step();

`ifdef ONCHIP_ARB_BOUNDS_CHECK_EN
    chk("oob_err_clear", oob_err, 1'b0);
    set_m(0, 1'b1, 1'b0, 16'd42500, 32'h0, 4'hF);
    exp_q0.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("oob_cs", ram_chipselect, 1'b0);
    chk("oob_wait", m0_waitrequest, 1'b0);
    step();
    idle_all();
    @(negedge clk);
    chk("oob_rdv", m0_readdatavalid, 1'b1);
    chk("oob_err_set", oob_err, 1'b1);
    step();
`endif

    repeat (3) step();
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
